// File: rtl/axi_lite_arb_pkg.sv
// Shared types and constants for the two-master AXI-Lite arbiter.
package axi_lite_arb_pkg;

    localparam int NUM_MASTERS = 2;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA
    } rd_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie, the master that was not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || last)) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Two AXI-Lite masters sharing one slave; write and read paths are arbitrated
// independently, and each grant is held for its whole transaction.
module axi_lite_arbiter
    import axi_lite_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    m_awvalid,
    input  logic [2*ADDR_WIDTH-1:0]       m_awaddr,
    output logic [1:0]                    m_awready,
    input  logic [1:0]                    m_wvalid,
    input  logic [2*DATA_WIDTH-1:0]       m_wdata,
    input  logic [2*DATA_WIDTH/8-1:0]     m_wstrb,
    output logic [1:0]                    m_wready,
    output logic [1:0]                    m_bvalid,
    input  logic [1:0]                    m_bready,
    input  logic [1:0]                    m_arvalid,
    input  logic [2*ADDR_WIDTH-1:0]       m_araddr,
    output logic [1:0]                    m_arready,
    output logic [1:0]                    m_rvalid,
    output logic [2*DATA_WIDTH-1:0]       m_rdata,
    input  logic [1:0]                    m_rready,
    output logic                          s_awvalid,
    output logic [ADDR_WIDTH-1:0]         s_awaddr,
    input  logic                          s_awready,
    output logic                          s_wvalid,
    output logic [DATA_WIDTH-1:0]         s_wdata,
    output logic [DATA_WIDTH/8-1:0]       s_wstrb,
    input  logic                          s_wready,
    input  logic                          s_bvalid,
    output logic                          s_bready,
    output logic                          s_arvalid,
    output logic [ADDR_WIDTH-1:0]         s_araddr,
    input  logic                          s_arready,
    input  logic                          s_rvalid,
    input  logic [DATA_WIDTH-1:0]         s_rdata,
    output logic                          s_rready,
    output logic [1:0]                    wr_grant,
    output logic [1:0]                    rd_grant
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    wr_state_t  wr_state_reg;
    logic [1:0] wr_grant_reg;
    logic       wr_last_reg;
    logic       aw_done_reg;
    logic       w_done_reg;

    rd_state_t  rd_state_reg;
    logic [1:0] rd_grant_reg;
    logic       rd_last_reg;

    logic [1:0] wr_req;
    logic [1:0] wr_pick;
    logic [1:0] rd_pick;
    logic       wr_idx;
    logic       rd_idx;
    logic       aw_pending;
    logic       w_pending;
    logic       ar_pending;
    logic       aw_hs;
    logic       w_hs;

    assign wr_req = m_awvalid | m_wvalid;
    assign wr_idx = wr_grant_reg[1];
    assign rd_idx = rd_grant_reg[1];

    rr_arb2 u_wr_arb (
        .req  (wr_req),
        .last (wr_last_reg),
        .gnt  (wr_pick)
    );

    rr_arb2 u_rd_arb (
        .req  (m_arvalid),
        .last (rd_last_reg),
        .gnt  (rd_pick)
    );

    // Downstream side is a pure mux of registered grant/state and upstream inputs.
    assign aw_pending = (wr_state_reg == W_ADDR) && !aw_done_reg;
    assign w_pending  = (wr_state_reg == W_ADDR) && !w_done_reg;
    assign ar_pending = (rd_state_reg == R_ADDR);

    assign s_awvalid = aw_pending && m_awvalid[wr_idx];
    assign s_awaddr  = !aw_pending ? '0 :
                       wr_idx ? m_awaddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_awaddr[ADDR_WIDTH-1:0];
    assign s_wvalid  = w_pending && m_wvalid[wr_idx];
    assign s_wdata   = !w_pending ? '0 :
                       wr_idx ? m_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : m_wdata[DATA_WIDTH-1:0];
    assign s_wstrb   = !w_pending ? '0 :
                       wr_idx ? m_wstrb[2*STRB_WIDTH-1:STRB_WIDTH] : m_wstrb[STRB_WIDTH-1:0];
    assign s_bready  = (wr_state_reg == W_RESP) && m_bready[wr_idx];

    assign s_arvalid = ar_pending && m_arvalid[rd_idx];
    assign s_araddr  = !ar_pending ? '0 :
                       rd_idx ? m_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_araddr[ADDR_WIDTH-1:0];
    assign s_rready  = (rd_state_reg == R_DATA) && m_rready[rd_idx];

    assign aw_hs = s_awvalid && s_awready;
    assign w_hs  = s_wvalid && s_wready;

    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
            assign m_awready[gi] = aw_pending && wr_grant_reg[gi] && s_awready;
            assign m_wready[gi]  = w_pending && wr_grant_reg[gi] && s_wready;
            assign m_bvalid[gi]  = (wr_state_reg == W_RESP) && wr_grant_reg[gi] && s_bvalid;
            assign m_arready[gi] = ar_pending && rd_grant_reg[gi] && s_arready;
            assign m_rvalid[gi]  = (rd_state_reg == R_DATA) && rd_grant_reg[gi] && s_rvalid;
            assign m_rdata[gi*DATA_WIDTH +: DATA_WIDTH] =
                ((rd_state_reg == R_DATA) && rd_grant_reg[gi]) ? s_rdata : '0;
        end
    endgenerate

    assign wr_grant = wr_grant_reg;
    assign rd_grant = rd_grant_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_reg <= W_IDLE;
            wr_grant_reg <= 2'b00;
            wr_last_reg  <= 1'b1;
            aw_done_reg  <= 1'b0;
            w_done_reg   <= 1'b0;
        end else begin
            case (wr_state_reg)
                W_IDLE: begin
                    if (|wr_req) begin
                        wr_grant_reg <= wr_pick;
                        wr_last_reg  <= wr_pick[1];
                        wr_state_reg <= W_ADDR;
                    end
                end
                W_ADDR: begin
                    if (aw_hs) aw_done_reg <= 1'b1;
                    if (w_hs)  w_done_reg  <= 1'b1;
                    if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) begin
                        wr_state_reg <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (s_bvalid && s_bready) begin
                        wr_state_reg <= W_IDLE;
                        wr_grant_reg <= 2'b00;
                        aw_done_reg  <= 1'b0;
                        w_done_reg   <= 1'b0;
                    end
                end
                default: wr_state_reg <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_reg <= R_IDLE;
            rd_grant_reg <= 2'b00;
            rd_last_reg  <= 1'b1;
        end else begin
            case (rd_state_reg)
                R_IDLE: begin
                    if (|m_arvalid) begin
                        rd_grant_reg <= rd_pick;
                        rd_last_reg  <= rd_pick[1];
                        rd_state_reg <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (s_arvalid && s_arready) rd_state_reg <= R_DATA;
                end
                R_DATA: begin
                    if (s_rvalid && s_rready) begin
                        rd_state_reg <= R_IDLE;
                        rd_grant_reg <= 2'b00;
                    end
                end
                default: rd_state_reg <= R_IDLE;
            endcase
        end
    end

endmodule
